// File: rtl/rf_arb_pkg.sv
// Shared types and sizes for the register-file writeback arbiter.
// The in-flight write bypass is enabled by defining RF_BYPASS_EN.
package rf_arb_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = $clog2(NREG);

  // One writeback request: destination register and the value to write.
  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  // Which requester wins when both are valid.
  typedef enum logic {
    GNT_S0 = 1'b0,
    GNT_S1 = 1'b1
  } grant_e;

  // Hand priority to the opposite requester after a contended grant.
  function automatic grant_e other_grant(input grant_e g);
    return (g == GNT_S0) ? GNT_S1 : GNT_S0;
  endfunction

endpackage

// File: rtl/rf_bypass_mux.sv
// One read port of the regfile, optionally forwarding the registered write that has not yet
// landed in the array. Forwarding is compiled in only when RF_BYPASS_EN is defined;
// otherwise the raw regfile data passes straight through.
module rf_bypass_mux
  import rf_arb_pkg::*;
(
  input  logic            i_we,
  input  logic [AW-1:0]   i_wa,
  input  logic [XLEN-1:0] i_wd,
  input  logic [AW-1:0]   i_ra,
  input  logic [XLEN-1:0] i_rf_rd,
  output logic [XLEN-1:0] o_rd
);

`ifdef RF_BYPASS_EN
  logic w_hit;

  // x0 is never forwarded: it always reads zero from the array.
  assign w_hit = i_we && (i_wa == i_ra) && (i_ra != '0);
  assign o_rd  = w_hit ? i_wd : i_rf_rd;
`else
  logic unused_bypass;

  // Write-port inputs are only needed when forwarding is built in.
  assign unused_bypass = ^{i_we, i_wa, i_wd, i_ra};
  assign o_rd          = i_rf_rd;
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the regfile write port between the ALU (S0) and load-unit (S1) writebacks.
// Round-robin only under contention; the write port is registered (one cycle latency);
// a saturating counter records cycles in which a valid requester was held off.
// Read-port forwarding of the in-flight write is enabled by defining RF_BYPASS_EN.
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  // S0: ALU writeback
  input  logic             i_s0_valid,
  output logic             o_s0_ready,
  input  logic [AW-1:0]    i_s0_rd,
  input  logic [XLEN-1:0]  i_s0_data,
  // S1: load-unit writeback
  input  logic             i_s1_valid,
  output logic             o_s1_ready,
  input  logic [AW-1:0]    i_s1_rd,
  input  logic [XLEN-1:0]  i_s1_data,
  // Regfile write port
  output logic             o_we3,
  output logic [AW-1:0]    o_a3,
  output logic [XLEN-1:0]  o_wd3,
  output logic [CNT_W-1:0] o_stall_cnt,
  // Regfile read ports
  input  logic [AW-1:0]    i_a1,
  input  logic [AW-1:0]    i_a2,
  input  logic [XLEN-1:0]  i_rf_rd1,
  input  logic [XLEN-1:0]  i_rf_rd2,
  output logic [XLEN-1:0]  o_rd1,
  output logic [XLEN-1:0]  o_rd2
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  grant_e           r_ptr;
  grant_e           w_ptr_next;
  logic             w_gnt_s0;
  logic             w_gnt_s1;
  logic             w_any_gnt;
  logic             w_contended;
  wb_req_t          w_req0;
  wb_req_t          w_req1;
  wb_req_t          w_sel_req;
  logic             r_we3;
  logic [AW-1:0]    r_a3;
  logic [XLEN-1:0]  r_wd3;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_req0      = '{rd: i_s0_rd, data: i_s0_data};
  assign w_req1      = '{rd: i_s1_rd, data: i_s1_data};
  assign w_contended = i_s0_valid & i_s1_valid;

  // Priority pointer register; S0 has priority out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= GNT_S0;
    end else begin
      r_ptr <= w_ptr_next;
    end
  end

  // Pointer moves only when a grant was made over a competing request.
  always_comb begin
    w_ptr_next = r_ptr;
    if (w_contended) begin
      w_ptr_next = other_grant(r_ptr);
    end
  end

  // Grant decode: a lone requester always wins, the pointer breaks ties.
  always_comb begin
    w_gnt_s0 = 1'b0;
    w_gnt_s1 = 1'b0;
    unique case ({i_s0_valid, i_s1_valid})
      2'b10:   w_gnt_s0 = 1'b1;
      2'b01:   w_gnt_s1 = 1'b1;
      2'b11: begin
        if (r_ptr == GNT_S0) begin
          w_gnt_s0 = 1'b1;
        end else begin
          w_gnt_s1 = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign o_s0_ready = w_gnt_s0;
  assign o_s1_ready = w_gnt_s1;
  assign w_any_gnt  = w_gnt_s0 | w_gnt_s1;
  assign w_sel_req  = w_gnt_s1 ? w_req1 : w_req0;

  // Write port: register the granted request; x0 is accepted but never enabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we3 <= 1'b0;
      r_a3  <= '0;
      r_wd3 <= '0;
    end else if (w_any_gnt) begin
      r_we3 <= (w_sel_req.rd != '0);
      r_a3  <= w_sel_req.rd;
      r_wd3 <= w_sel_req.data;
    end else begin
      r_we3 <= 1'b0;
    end
  end

  // Stall counter: at most one loser per cycle, and only when both are valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_contended && (r_stall_cnt != CntMax)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign o_we3       = r_we3;
  assign o_a3        = r_a3;
  assign o_wd3       = r_wd3;
  assign o_stall_cnt = r_stall_cnt;

  rf_bypass_mux u_byp1 (
    .i_we    (r_we3),
    .i_wa    (r_a3),
    .i_wd    (r_wd3),
    .i_ra    (i_a1),
    .i_rf_rd (i_rf_rd1),
    .o_rd    (o_rd1)
  );

  rf_bypass_mux u_byp2 (
    .i_we    (r_we3),
    .i_wa    (r_a3),
    .i_wd    (r_wd3),
    .i_ra    (i_a2),
    .i_rf_rd (i_rf_rd2),
    .o_rd    (o_rd2)
  );

endmodule
